mac_rx_sched: RTL and testbench
===============================

Name: mac_rx_sched

Overview:
- Ingress scheduler for the 4-port receive path. Selects which PHY frame-FIFO the MAC decoder services next and hands the decoder a port ID through a grant/ack/done handshake.
- Selection uses per-port urgency (afull > half > frame_exist), round-robin within equal urgency, an aging override against starvation, and a service watchdog.
- Sits between the four PHY FIFOs' status flags and the decoder's port-select input.

Parameters:
- AGE_WIDTH, 8, width of per-port wait counters.
- AGE_LIMIT, 200, wait cycles after which a pending port is promoted to starvation level; must be < 2^AGE_WIDTH.
- TMO_WIDTH, 16, width of the busy watchdog counter.
- TMO_LIMIT, 40000, busy cycles before the watchdog aborts a grant.

Ports:
- clk  in  1  system clock (decoder domain).
- rst  in  1  synchronous active-high reset.
- frame_exist  in  4  per-port complete-frame-present flag; clk domain, used directly.
- fifo_half  in  4  per-port half-full flag; write-clock domain, 2FF-synchronized internally.
- fifo_afull  in  4  per-port almost-full flag; write-clock domain, 2FF-synchronized internally.
- port_en  in  4  per-port scheduling enable (static config).
- dec_ready  in  1  decoder idle and header/body FIFOs have room for a max frame.
- grant_valid  out  1  offer of grant_id to the decoder.
- grant_id  out  2  selected port.
- grant_ack  in  1  one-cycle pulse: decoder accepted the offer.
- dec_done  in  1  one-cycle pulse: decoder finished the frame (including the abort path).
- busy  out  1  grant accepted, frame in service.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- starve_vec  out  4  per-port age counter saturated at AGE_LIMIT.

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant_valid=0, grant_id=0, busy=0, timeout_err=0, starve_vec=0.
  - All age counters, the watchdog and the synchronizer flops = 0.
  - last_id=3, so the first tie resolves to port 0.
  - state=S_IDLE.
  - Reset mid-frame aborts immediately; no dec_done is required.
- Synchronization: fifo_half/fifo_afull pass through 2 flops; a change is visible to level logic 2 cycles later.
- Per-port level (combinational, masked: port_en=0 gives level 0):
  - 4 if age==AGE_LIMIT.
  - else 3 if afull_sync.
  - else 2 if half_sync.
  - else 1 if frame_exist.
  - else 0.
- Selection: highest level wins; ties are searched from last_id+1 upward, modulo 4.
- Aging: each cycle, a port with level>=1 that is not the currently offered or served port increments its age, saturating at AGE_LIMIT. The age of grant_id clears on grant_ack. starve_vec[i] = (age_i==AGE_LIMIT).
- FSM:
  - S_IDLE: if dec_ready=1 and any level>=1, register grant_id=winner and grant_valid=1 next cycle, and go to S_OFFER. Otherwise stay.
  - S_OFFER:
    - grant_id is held stable and grant_valid=1 until grant_ack, even if the port's level changes.
    - If port_en[grant_id] drops before ack: grant_valid=0, go to S_IDLE (retract).
    - If grant_ack and the drop occur in the same cycle, ack wins.
    - On grant_ack: grant_valid=0, busy=1, last_id=grant_id, watchdog=0, go to S_BUSY.
    - dec_done in S_OFFER is ignored.
  - S_BUSY:
    - Watchdog increments each cycle.
    - On dec_done: busy=0, go to S_IDLE. The earliest new offer is 2 cycles after dec_done.
    - If the watchdog reaches TMO_LIMIT without dec_done: timeout_err=1 for one cycle, busy=0, go to S_IDLE.
    - dec_done on the same cycle the watchdog hits the limit counts as done; no error.
    - grant_ack in S_BUSY is ignored.
  - Illegal state encoding: go to S_IDLE with all outputs cleared.
- Latency: dec_ready+candidate at cycle N gives grant_valid at N+1. A pending port waits at most 3 frame services at equal level.

Test Plan:
- Reset then frame_exist=4'b0101, dec_ready=1 -> grant_valid at cycle 1, grant_id=0; ack, then done -> next grant_id=2 (round-robin), then 0.
- frame_exist=4'b1111, fifo_afull=4'b0100 held for 3 cycles -> grant_id=2 regardless of last_id; fifo_afull toggled for 1 cycle only -> no effect until 2-cycle sync delay elapses.
- Port 3 frame_exist=1 while port 0 fifo_afull=1 is continuously re-granted -> starve_vec[3]=1 after 200 waiting cycles, next grant_id=3, starve_vec[3] clears on ack.
- Offer to port 1, deassert port_en[1] before ack -> grant_valid falls next cycle, no busy; same cycle with grant_ack=1 -> busy=1.
- Ack then no dec_done (TMO_LIMIT=16 override) -> timeout_err pulse exactly 16 cycles after ack, busy=0; dec_done on cycle 16 -> no timeout_err.
- rst=1 while busy=1 -> all outputs 0 next cycle, next grant goes to port 0 on tie.

Source files
------------

// File: rtl/mac_rx_sched.sv
// mac_rx_sched: ingress scheduler choosing which of four PHY frame FIFOs the
// MAC decoder services next, with a grant/ack/done handshake to the decoder.
//
// Ports:
//   clk, rst            decoder-domain clock, synchronous active-high reset
//   frame_exist[3:0]    complete frame present (clk domain)
//   fifo_half[3:0]      half-full flags (write domain, synchronized here)
//   fifo_afull[3:0]     almost-full flags (write domain, synchronized here)
//   port_en[3:0]        static per-port scheduling enable
//   dec_ready           decoder can take a maximum-size frame
//   grant_valid/id      offer of a port to the decoder
//   grant_ack           decoder accepted the offer (pulse)
//   dec_done            decoder finished the frame (pulse)
//   busy                frame in service
//   timeout_err         watchdog aborted the grant (pulse)
//   starve_vec[3:0]     per-port age counter saturated
module mac_rx_sched #(
    parameter int AGE_WIDTH = 8,
    parameter int AGE_LIMIT = 200,
    parameter int TMO_WIDTH = 16,
    parameter int TMO_LIMIT = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] frame_exist,
    input  logic [3:0] fifo_half,
    input  logic [3:0] fifo_afull,
    input  logic [3:0] port_en,
    input  logic       dec_ready,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    input  logic       grant_ack,
    input  logic       dec_done,
    output logic       busy,
    output logic       timeout_err,
    output logic [3:0] starve_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(AGE_LIMIT);
    localparam logic [TMO_WIDTH-1:0] TMO_END = TMO_WIDTH'(TMO_LIMIT - 1);

    state_t               state_q;
    logic                 grant_valid_q;
    logic [1:0]           grant_id_q;
    logic                 busy_q;
    logic                 timeout_err_q;
    logic [1:0]           last_id_q;
    logic [TMO_WIDTH-1:0] wd_q;
    logic [3:0]           half_s1_q, half_s2_q;
    logic [3:0]           afull_s1_q, afull_s2_q;
    logic [AGE_WIDTH-1:0] age_q [4];
    logic [AGE_WIDTH-1:0] age_d [4];

    logic [2:0] lvl [4];
    logic [2:0] best_lvl;
    logic [1:0] win_id;
    logic [1:0] idx;
    logic       serving;

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign serving     = (state_q == S_OFFER) || (state_q == S_BUSY);

    // Urgency per port; a saturated age outranks every FIFO flag.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (!port_en[i])
                lvl[i] = 3'd0;
            else if (age_q[i] == AGE_MAX)
                lvl[i] = 3'd4;
            else if (afull_s2_q[i])
                lvl[i] = 3'd3;
            else if (fifo_half[i] && 1'b0)
                lvl[i] = 3'd2;
            else if (half_s2_q[i])
                lvl[i] = 3'd2;
            else if (frame_exist[i])
                lvl[i] = 3'd1;
            else
                lvl[i] = 3'd0;
        end
    end

    // Scan starts just after the last served port; strict '>' keeps the
    // first port found at the top level, giving round-robin among ties.
    always_comb begin
        best_lvl = 3'd0;
        win_id   = 2'd0;
        idx      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_id_q + 2'(k);
            if (lvl[idx] > best_lvl) begin
                best_lvl = lvl[idx];
                win_id   = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            age_d[i] = age_q[i];
            if (lvl[i] != 3'd0 && age_q[i] != AGE_MAX
                && !(serving && grant_id_q == 2'(i)))
                age_d[i] = age_q[i] + 1'b1;
            if (state_q == S_OFFER && grant_ack && grant_id_q == 2'(i))
                age_d[i] = '0;
            starve_vec[i] = (age_q[i] == AGE_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= 2'd0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            last_id_q     <= 2'd3;
            wd_q          <= '0;
            half_s1_q     <= '0;
            half_s2_q     <= '0;
            afull_s1_q    <= '0;
            afull_s2_q    <= '0;
            for (int i = 0; i < 4; i++)
                age_q[i] <= '0;
        end else begin
            half_s1_q     <= fifo_half;
            half_s2_q     <= half_s1_q;
            afull_s1_q    <= fifo_afull;
            afull_s2_q    <= afull_s1_q;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < 4; i++)
                age_q[i] <= age_d[i];
            case (state_q)
                S_IDLE: begin
                    if (dec_ready && best_lvl != 3'd0) begin
                        grant_id_q    <= win_id;
                        grant_valid_q <= 1'b1;
                        state_q       <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (grant_ack) begin
                        grant_valid_q <= 1'b0;
                        busy_q        <= 1'b1;
                        last_id_q     <= grant_id_q;
                        wd_q          <= '0;
                        state_q       <= S_BUSY;
                    end else if (!port_en[grant_id_q]) begin
                        grant_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (dec_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wd_q == TMO_END) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    grant_valid_q <= 1'b0;
                    grant_id_q    <= 2'd0;
                    busy_q        <= 1'b0;
                    timeout_err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_rx_sched.sv
// tb_mac_rx_sched: directed scenarios plus randomized traffic, every cycle
// compared against a cycle-level behavioural model of the scheduler.
module tb_mac_rx_sched;

    localparam int AL = 200;
    localparam int TL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fe, half, afull, en;
    logic       dec_ready, ack, done;
    logic       gv;
    logic [1:0] gid;
    logic       busy, terr;
    logic [3:0] starve;

    always #5 clk = ~clk;

    mac_rx_sched #(
        .AGE_WIDTH(8),
        .AGE_LIMIT(AL),
        .TMO_WIDTH(16),
        .TMO_LIMIT(TL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_exist(fe),
        .fifo_half(half),
        .fifo_afull(afull),
        .port_en(en),
        .dec_ready(dec_ready),
        .grant_valid(gv),
        .grant_id(gid),
        .grant_ack(ack),
        .dec_done(done),
        .busy(busy),
        .timeout_err(terr),
        .starve_vec(starve)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: flags, ages as plain ints, sync delay as a queue,
    // watchdog as "cycles since ack".
    bit         m_offer, m_busy, m_terr;
    int         m_gid, m_last, m_since, m_cyc;
    int         m_age [4];
    logic [3:0] half_q [$];
    logic [3:0] afull_q [$];

    function automatic int level(int i, logic [3:0] hv, logic [3:0] av);
        if (!en[i]) return 0;
        if (m_age[i] == AL) return 4;
        if (av[i]) return 3;
        if (hv[i]) return 2;
        if (fe[i]) return 1;
        return 0;
    endfunction

    task automatic model_step();
        int lv [4];
        int best, win, s, d;
        logic [3:0] hv, av;
        m_cyc++;
        if (rst) begin
            m_offer = 0; m_busy = 0; m_terr = 0;
            m_gid = 0; m_last = 3;
            foreach (m_age[i]) m_age[i] = 0;
            half_q = '{4'h0, 4'h0};
            afull_q = '{4'h0, 4'h0};
            return;
        end
        hv = half_q.pop_front();
        av = afull_q.pop_front();
        half_q.push_back(half);
        afull_q.push_back(afull);
        best = -1; win = 0;
        for (int i = 0; i < 4; i++) begin
            lv[i] = level(i, hv, av);
            d = (i - m_last + 7) % 4;
            s = lv[i] * 8 + (3 - d);
            if (lv[i] > 0 && s > best) begin
                best = s; win = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (m_offer && ack && i == m_gid)
                m_age[i] = 0;
            else if (lv[i] > 0 && m_age[i] < AL
                     && !((m_offer || m_busy) && i == m_gid))
                m_age[i]++;
        end
        m_terr = 0;
        if (m_offer) begin
            if (ack) begin
                m_offer = 0; m_busy = 1;
                m_last = m_gid; m_since = m_cyc;
            end else if (!en[m_gid]) begin
                m_offer = 0;
            end
        end else if (m_busy) begin
            if (done) m_busy = 0;
            else if (m_cyc - m_since == TL) begin
                m_terr = 1; m_busy = 0;
            end
        end else if (dec_ready && best >= 0) begin
            m_gid = win; m_offer = 1;
        end
    endtask

    task automatic cyc();
        logic [3:0] sv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) sv[i] = (m_age[i] == AL);
        chk("grant_valid", gv, m_offer);
        chk("grant_id", gid, m_gid);
        chk("busy", busy, m_busy);
        chk("timeout_err", terr, m_terr);
        chk("starve_vec", starve, sv);
    endtask

    task automatic do_reset();
        rst = 1; ack = 0; done = 0;
        cyc();
        rst = 0;
    endtask

    bit saw_starve, saw_g3;

    initial begin
        rst = 1; fe = 0; half = 0; afull = 0; en = 4'hF;
        dec_ready = 0; ack = 0; done = 0;
        cyc();
        cyc();
        rst = 0;
        chk("reset_gv", gv, 0);
        chk("reset_busy", busy, 0);

        // Round-robin between ports 0 and 2.
        fe = 4'b0101; dec_ready = 1;
        cyc();
        chk("rr_first", gid, 0);
        ack = 1; cyc(); ack = 0;
        done = 1; cyc(); done = 0;
        cyc();
        chk("rr_second", gid, 2);
        ack = 1; cyc(); ack = 0;
        done = 1; cyc(); done = 0;
        cyc();
        chk("rr_third", gid, 0);
        ack = 1; cyc(); ack = 0;
        done = 1; cyc(); done = 0;

        // Almost-full wins once it has crossed the synchronizer.
        dec_ready = 0; fe = 4'hF; afull = 4'b0100;
        repeat (3) cyc();
        dec_ready = 1; cyc();
        chk("afull_win", gid, 2);
        ack = 1; cyc(); ack = 0;
        afull = 4'b1000; done = 1; cyc();
        afull = 4'b0000; done = 0;
        repeat (4) cyc();

        // Starvation: port 0 kept almost full, port 3 only has a frame.
        do_reset();
        fe = 4'b1001; afull = 4'b0001; en = 4'hF;
        dec_ready = 1; ack = 1; done = 1;
        saw_starve = 0; saw_g3 = 0;
        repeat (320) begin
            cyc();
            if (starve[3]) saw_starve = 1;
            if (gv && gid == 2'd3) saw_g3 = 1;
        end
        chk("starve_seen", saw_starve, 1);
        chk("starve_grant", saw_g3, 1);
        ack = 0; done = 0; afull = 0;

        // Retract on port_en drop, and ack winning over the drop.
        do_reset();
        fe = 4'b0010; dec_ready = 1;
        cyc();
        chk("retract_offer", gid, 1);
        en = 4'b1101; cyc();
        chk("retract_gv", gv, 0);
        chk("retract_busy", busy, 0);
        en = 4'hF; cyc();
        en = 4'b1101; ack = 1; cyc();
        chk("ack_wins", busy, 1);
        en = 4'hF; ack = 0; done = 1; cyc(); done = 0;

        // Watchdog abort, then done on the limit cycle.
        do_reset();
        fe = 4'b0001; cyc();
        ack = 1; cyc(); ack = 0; fe = 0;
        repeat (TL - 1) cyc();
        chk("tmo_early", terr, 0);
        cyc();
        chk("tmo_pulse", terr, 1);
        chk("tmo_busy", busy, 0);
        fe = 4'b0001; cyc(); cyc();
        ack = 1; cyc(); ack = 0; fe = 0;
        repeat (TL - 1) cyc();
        done = 1; cyc(); done = 0;
        chk("tmo_done_wins", terr, 0);

        // Reset while busy.
        fe = 4'b0100; cyc(); cyc();
        ack = 1; cyc(); ack = 0;
        rst = 1; cyc(); rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_gv", gv, 0);
        fe = 4'hF; cyc();
        chk("rst_tie", gid, 0);

        // Randomized traffic.
        repeat (4000) begin
            rst       = ($urandom_range(0, 499) == 0);
            fe        = 4'($urandom);
            half      = 4'($urandom);
            afull     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            en        = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
            dec_ready = ($urandom_range(0, 3) != 0);
            ack       = ($urandom_range(0, 2) == 0);
            done      = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
